hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline control for the 5-stage core: decides stall/flush/enable for PC and the
//  IF/ID, ID/EX, EX/MEM, MEM/WB latches each cycle. Sits beside the forwarding logic:
//  handles what forwarding cannot (load-use, memory wait, taken branch, halt).
//  Tracks outstanding data-memory waits and halt in a small FSM.
// PARAMETERS
//  MAX_DWAIT  256  cycles in DWAIT before sticky dwait_timeout sets
//  CNT_W      32   width of perf counters (HAZARD_PERF_EN only)
// PORTS
//  CLK            in   1   clock, rising edge
//  nRST           in   1   synchronous active-low reset
//  id_rsel1       in   5   rs of instruction in ID
//  id_rsel2       in   5   rt of instruction in ID
//  id_usesRt      in   1   ID instruction reads rt as a source
//  ex_memRead     in   1   EX instruction is a load
//  ex_writeReg    in   5   EX destination register
//  mem_dREN       in   1   MEM stage data read
//  mem_dWEN       in   1   MEM stage data write
//  dhit           in   1   data access completes this cycle
//  ihit           in   1   fetch completes this cycle
//  mem_pcSrc      in   1   taken branch/jump resolved in MEM
//  mem_halt       in   1   halt instruction in MEM
//  pc_en          out  1   PC update enable
//  ifid_en/ifid_flush, idex_en/idex_flush, exmem_en/exmem_flush, memwb_en/memwb_flush
//                 out  1 each  latch hold(en=0) / bubble(flush=1, wins over en)
//  halted         out  1   core halted
//  dwait_timeout  out  1   sticky: DWAIT exceeded MAX_DWAIT
//  stall_cycles, flush_events, dwait_cycles  out CNT_W  perf counters
// BEHAVIOUR
//  Control outputs are combinational from state + inputs (zero latency). FSM: RUN, DWAIT, HALTED.
//  nRST=0 at edge: state<=RUN, counters<=0, dwait_timeout<=0. While nRST=0: all en=0, all flush=1,
//   halted=0. Counter/flag outputs reset to 0.
//  RUN priority, first match wins:
//   1 mem_halt: pc_en=0; ifid/idex/exmem flush=1; memwb_en=1. Next state HALTED.
//   2 (mem_dREN|mem_dWEN)&!dhit: pc/ifid/idex/exmem en=0; memwb_flush=1. Next DWAIT.
//   3 mem_pcSrc: pc_en=1; ifid/idex/exmem flush=1; memwb_en=1.
//   4 load-use: ex_memRead & ex_writeReg!=0 & (==id_rsel1 | (id_usesRt & ==id_rsel2)):
//     pc_en=0, ifid_en=0, idex_flush=1, rest advance. Exactly one bubble per hazard.
//   5 !ihit: pc_en=0, ifid_flush=1, rest advance.
//   6 else: all en=1, all flush=0.
//  DWAIT: while !dhit same outputs as rule 2; ihit ignored (data side has memory priority).
//   dhit cycle: outputs per RUN rules 3-6 (rule 1 also applies if mem_halt); next RUN.
//  dwait_cnt (internal) +1 per DWAIT cycle, clears on leaving DWAIT; reaching MAX_DWAIT
//   sets dwait_timeout until reset; FSM stays in DWAIT (no abort).
//  HALTED: all en=0, all flush=0, halted=1; exits only on reset.
//  Simultaneous load-use + !ihit: rule 4 wins; fetch retried next cycle with PC held.
// CONFIGURATION
//  HAZARD_PERF_EN defined: stall_cycles += 1 when pc_en=0 in RUN/DWAIT; flush_events += 1 on
//   rule 3; dwait_cycles += 1 per DWAIT cycle; all saturate at 2^CNT_W-1.
//  Not defined: counters not built, the three ports tied to 0.
// STRUCTURE
//  cpu_types_pkg: regbits_t (5-bit), hazard_state_t enum {RUN, DWAIT, HALTED}.
//  Sub-module sat_counter #(CNT_W) (inc, clear -> count), instantiated 3x under HAZARD_PERF_EN.
// TESTING
//  ex_memRead=1, ex_writeReg=8, id_rsel1=8 -> 1 cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all en.
//  Same with ex_writeReg=0 -> no stall; id_rsel2=8, id_usesRt=0 -> no stall.
//  mem_dREN=1, dhit low 3 cycles -> DWAIT 3 cycles, memwb_flush=1, dwait_cycles=3, then RUN.
//  mem_pcSrc=1 with load-use active -> flushes only, pc_en=1, no stall.
//  mem_halt=1 -> HALTED next cycle, halted=1; nRST low 1 cycle -> RUN, halted=0.
//  MAX_DWAIT=4, dhit held low 6 cycles -> dwait_timeout=1 and stays 1 after dhit.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the core's pipeline control: register index, hazard FSM states and
// the per-latch control bundle driven by hazard_unit.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
        logic memwb_flush;
    } hazard_ctrl_t;

    // Bit groups: pc | ifid en,flush | idex en,flush | exmem en,flush | memwb en,flush
    localparam hazard_ctrl_t CTRL_ADVANCE    = 9'b1_10_10_10_10;
    localparam hazard_ctrl_t CTRL_RESET      = 9'b0_01_01_01_01;
    localparam hazard_ctrl_t CTRL_HOLD_ALL   = 9'b0_00_00_00_00;
    localparam hazard_ctrl_t CTRL_HALT_DRAIN = 9'b0_01_01_01_10;
    localparam hazard_ctrl_t CTRL_DWAIT      = 9'b0_00_00_00_01;
    localparam hazard_ctrl_t CTRL_BRANCH     = 9'b1_01_01_01_10;
    localparam hazard_ctrl_t CTRL_LOAD_USE   = 9'b0_00_01_10_10;
    localparam hazard_ctrl_t CTRL_FETCH_MISS = 9'b0_01_10_10_10;

    function automatic logic is_load_use(
        input logic     ex_mem_read,
        input regbits_t ex_wr,
        input regbits_t rs,
        input regbits_t rt,
        input logic     uses_rt
    );
        return ex_mem_read && (ex_wr != '0) &&
               ((ex_wr == rs) || (uses_rt && (ex_wr == rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for the hazard perf counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush/enable control for the 5-stage core (load-use, data wait, branch, halt).
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
//
//   state  | meaning
//   RUN    | normal issue; priority rules halt > data wait > branch > load-use > fetch miss
//   DWAIT  | data access outstanding; pipeline frozen, MEM/WB bubbled until dhit
//   HALTED | halt retired into WB; everything held until reset
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int MAX_DWAIT = 256,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  regbits_t         id_rsel1,
    input  regbits_t         id_rsel2,
    input  logic             id_usesRt,
    input  logic             ex_memRead,
    input  regbits_t         ex_writeReg,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             mem_pcSrc,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic             dwait_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] dwait_cycles
);

    localparam int WCNT_W = $clog2(MAX_DWAIT + 1);
    localparam logic [WCNT_W-1:0] DWAIT_LIMIT = WCNT_W'(MAX_DWAIT);

    hazard_state_t     state_q, state_d;
    logic [WCNT_W-1:0] dwait_cnt_q, dwait_cnt_d, dwait_cnt_inc;
    logic              dwait_timeout_q, dwait_timeout_d;
    hazard_ctrl_t      ctrl;
    logic              data_busy;
    logic              load_use;

    assign data_busy = (mem_dREN || mem_dWEN) && !dhit;
    assign load_use  = is_load_use(ex_memRead, ex_writeReg, id_rsel1, id_rsel2, id_usesRt);

    always_comb begin
        ctrl    = CTRL_ADVANCE;
        state_d = state_q;
        case (state_q)
            RUN, DWAIT: begin
                if ((state_q == DWAIT) && !dhit) begin
                    ctrl    = CTRL_DWAIT;
                    state_d = DWAIT;
                end else if (mem_halt) begin
                    ctrl    = CTRL_HALT_DRAIN;
                    state_d = HALTED;
                end else if (data_busy) begin
                    ctrl    = CTRL_DWAIT;
                    state_d = DWAIT;
                end else begin
                    state_d = RUN;
                    if (mem_pcSrc) begin
                        ctrl = CTRL_BRANCH;
                    end else if (load_use) begin
                        // load-use outranks a fetch miss: PC is held, so the fetch simply retries
                        ctrl = CTRL_LOAD_USE;
                    end else if (!ihit) begin
                        ctrl = CTRL_FETCH_MISS;
                    end
                end
            end
            HALTED: begin
                ctrl = CTRL_HOLD_ALL;
            end
            default: begin
                ctrl    = CTRL_RESET;
                state_d = RUN;
            end
        endcase
        if (!nRST) begin
            ctrl = CTRL_RESET;
        end
    end

    // Count saturates at the limit so a stuck access cannot wrap and re-arm anything.
    assign dwait_cnt_inc   = (dwait_cnt_q == DWAIT_LIMIT) ? dwait_cnt_q : dwait_cnt_q + WCNT_W'(1);
    assign dwait_cnt_d     = ((state_q == DWAIT) && (state_d == DWAIT)) ? dwait_cnt_inc : '0;
    assign dwait_timeout_d = dwait_timeout_q ||
                             ((state_q == DWAIT) && (dwait_cnt_inc == DWAIT_LIMIT));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q         <= RUN;
            dwait_cnt_q     <= '0;
            dwait_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            dwait_cnt_q     <= dwait_cnt_d;
            dwait_timeout_q <= dwait_timeout_d;
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign ifid_en       = ctrl.ifid_en;
    assign ifid_flush    = ctrl.ifid_flush;
    assign idex_en       = ctrl.idex_en;
    assign idex_flush    = ctrl.idex_flush;
    assign exmem_en      = ctrl.exmem_en;
    assign exmem_flush   = ctrl.exmem_flush;
    assign memwb_en      = ctrl.memwb_en;
    assign memwb_flush   = ctrl.memwb_flush;
    assign halted        = nRST && (state_q == HALTED);
    assign dwait_timeout = dwait_timeout_q;

`ifdef HAZARD_PERF_EN
    logic stall_inc, flush_inc, dwait_inc;

    assign stall_inc = nRST && (state_q != HALTED) && !ctrl.pc_en;
    assign flush_inc = nRST && ((state_q == RUN) || ((state_q == DWAIT) && dhit)) &&
                       !mem_halt && !data_busy && mem_pcSrc;
    assign dwait_inc = nRST && (state_q == DWAIT);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (CLK),
        .clear_i (!nRST),
        .inc_i   (stall_inc),
        .count_o (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (CLK),
        .clear_i (!nRST),
        .inc_i   (flush_inc),
        .count_o (flush_events)
    );

    sat_counter #(.CNT_W(CNT_W)) u_dwait_cnt (
        .clk_i   (CLK),
        .clear_i (!nRST),
        .inc_i   (dwait_inc),
        .count_o (dwait_cycles)
    );
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
    assign dwait_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios then randomized traffic,
// all checked against a cycle-level behavioural model of the pipeline rules.
module tb_hazard_unit;

    localparam int MAXW = 4;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [1:0] HOLD = 2'd0;
    localparam logic [1:0] ADV  = 2'd1;
    localparam logic [1:0] BUB  = 2'd2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [4:0]  id_rsel1, id_rsel2, ex_writeReg;
    logic        id_usesRt, ex_memRead, mem_dREN, mem_dWEN, dhit, ihit, mem_pcSrc, mem_halt;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halted, dwait_timeout;
    logic [31:0] stall_cycles, flush_events, dwait_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // model: 0 running, 1 waiting on data, 2 halted
    int              m_mode = 0;
    int              m_wait_len = 0;
    bit              m_timeout = 1'b0;
    longint unsigned m_stall = 0, m_flush = 0, m_dwc = 0;

    always #5 CLK = ~CLK;

    hazard_unit #(.MAX_DWAIT(MAXW), .CNT_W(32)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .id_rsel1      (id_rsel1),
        .id_rsel2      (id_rsel2),
        .id_usesRt     (id_usesRt),
        .ex_memRead    (ex_memRead),
        .ex_writeReg   (ex_writeReg),
        .mem_dREN      (mem_dREN),
        .mem_dWEN      (mem_dWEN),
        .dhit          (dhit),
        .ihit          (ihit),
        .mem_pcSrc     (mem_pcSrc),
        .mem_halt      (mem_halt),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .ifid_flush    (ifid_flush),
        .idex_en       (idex_en),
        .idex_flush    (idex_flush),
        .exmem_en      (exmem_en),
        .exmem_flush   (exmem_flush),
        .memwb_en      (memwb_en),
        .memwb_flush   (memwb_flush),
        .halted        (halted),
        .dwait_timeout (dwait_timeout),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events),
        .dwait_cycles  (dwait_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] act(input logic en, input logic fl);
        return fl ? BUB : (en ? ADV : HOLD);
    endfunction

    task automatic set_idle();
        id_rsel1 = 5'd1; id_rsel2 = 5'd2; id_usesRt = 1'b1;
        ex_memRead = 1'b0; ex_writeReg = 5'd0;
        mem_dREN = 1'b0; mem_dWEN = 1'b0; dhit = 1'b1; ihit = 1'b1;
        mem_pcSrc = 1'b0; mem_halt = 1'b0;
    endtask

    // Inputs are set just after a rising edge; outputs are checked at the falling edge.
    task automatic run_cycle(input string tag);
        logic [1:0] a1, a2, a3, a4;
        logic       pc;
        int         nmode;
        bit         flush_ev, lu, busy;
        @(negedge CLK);
        chk({tag, ":timeout"}, 64'(dwait_timeout), 64'(m_timeout));
        chk({tag, ":stall_cnt"}, 64'(stall_cycles), PERF ? 64'(m_stall) : 64'd0);
        chk({tag, ":flush_cnt"}, 64'(flush_events), PERF ? 64'(m_flush) : 64'd0);
        chk({tag, ":dwait_cnt"}, 64'(dwait_cycles), PERF ? 64'(m_dwc) : 64'd0);
        if (!nRST) begin
            chk({tag, ":rst_ctrl"},
                64'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                     exmem_en, exmem_flush, memwb_en, memwb_flush, halted}),
                64'(10'b0_01_01_01_01_0));
            m_mode = 0; m_wait_len = 0; m_timeout = 1'b0;
            m_stall = 0; m_flush = 0; m_dwc = 0;
        end else begin
            lu = ex_memRead && (ex_writeReg != 0) &&
                 ((ex_writeReg == id_rsel1) || (id_usesRt && (ex_writeReg == id_rsel2)));
            busy = (mem_dREN || mem_dWEN) && !dhit;
            flush_ev = 1'b0;
            nmode = 0;
            pc = 1'b1; a1 = ADV; a2 = ADV; a3 = ADV; a4 = ADV;
            if (m_mode == 2) begin
                pc = 1'b0; a1 = HOLD; a2 = HOLD; a3 = HOLD; a4 = HOLD; nmode = 2;
            end else if ((m_mode == 1 && !dhit) || (!mem_halt && busy)) begin
                pc = 1'b0; a1 = HOLD; a2 = HOLD; a3 = HOLD; a4 = BUB; nmode = 1;
            end else if (mem_halt) begin
                pc = 1'b0; a1 = BUB; a2 = BUB; a3 = BUB; nmode = 2;
            end else if (mem_pcSrc) begin
                a1 = BUB; a2 = BUB; a3 = BUB; flush_ev = 1'b1;
            end else if (lu) begin
                pc = 1'b0; a1 = HOLD; a2 = BUB;
            end else if (!ihit) begin
                pc = 1'b0; a1 = BUB;
            end
            chk({tag, ":ctrl"},
                64'({pc_en, act(ifid_en, ifid_flush), act(idex_en, idex_flush),
                     act(exmem_en, exmem_flush), act(memwb_en, memwb_flush), halted}),
                64'({pc, a1, a2, a3, a4, (m_mode == 2)}));
            if (m_mode != 2 && !pc) m_stall++;
            if (flush_ev) m_flush++;
            if (m_mode == 1) begin
                m_dwc++;
                m_wait_len++;
                if (m_wait_len >= MAXW) m_timeout = 1'b1;
            end
            if (nmode != 1) m_wait_len = 0;
            m_mode = nmode;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        set_idle();
        nRST = 1'b0;
        run_cycle("reset0");
        run_cycle("reset1");
        nRST = 1'b1;
        run_cycle("idle0");
        run_cycle("idle1");

        ex_memRead = 1'b1; ex_writeReg = 5'd8; id_rsel1 = 5'd8;
        run_cycle("lu_rs");
        ex_memRead = 1'b0;
        run_cycle("lu_after");
        ex_memRead = 1'b1; ex_writeReg = 5'd0; id_rsel1 = 5'd0;
        run_cycle("lu_r0");
        ex_writeReg = 5'd8; id_rsel1 = 5'd3; id_rsel2 = 5'd8; id_usesRt = 1'b0;
        run_cycle("lu_rt_unused");
        id_usesRt = 1'b1;
        run_cycle("lu_rt_used");
        ihit = 1'b0;
        run_cycle("lu_and_imiss");
        ex_memRead = 1'b0;
        run_cycle("imiss");
        set_idle();

        mem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle("dwait3");
        dhit = 1'b1;
        run_cycle("dwait3_hit");
        set_idle();
        run_cycle("dwait3_done");

        ex_memRead = 1'b1; ex_writeReg = 5'd8; id_rsel1 = 5'd8; mem_pcSrc = 1'b1;
        run_cycle("branch_lu");
        set_idle();

        mem_dWEN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 6; i++) run_cycle("dwait6");
        dhit = 1'b1;
        run_cycle("dwait6_hit");
        set_idle();
        run_cycle("dwait6_done");
        chk("timeout_sticky", 64'(dwait_timeout), 64'd1);

        mem_halt = 1'b1;
        run_cycle("halt");
        mem_halt = 1'b0;
        chk("halted_set", 64'(halted), 64'd1);
        run_cycle("halted0");
        ihit = 1'b0; mem_pcSrc = 1'b1;
        run_cycle("halted1");
        set_idle();
        nRST = 1'b0;
        run_cycle("halt_reset");
        nRST = 1'b1;
        chk("halted_clear", 64'(halted), 64'd0);
        run_cycle("post_reset");

        for (int n = 0; n < 3000; n++) begin
            id_rsel1    = 5'($urandom_range(0, 3));
            id_rsel2    = 5'($urandom_range(0, 3));
            ex_writeReg = 5'($urandom_range(0, 3));
            id_usesRt   = 1'($urandom_range(0, 1));
            ex_memRead  = 1'($urandom_range(0, 1));
            mem_dREN    = ($urandom_range(0, 3) == 0);
            mem_dWEN    = ($urandom_range(0, 7) == 0);
            dhit        = 1'($urandom_range(0, 1));
            ihit        = ($urandom_range(0, 3) != 0);
            mem_pcSrc   = ($urandom_range(0, 5) == 0);
            mem_halt    = ($urandom_range(0, 49) == 0);
            nRST        = (m_mode == 2) ? ($urandom_range(0, 3) != 0)
                                        : ($urandom_range(0, 39) != 0);
            run_cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
